mag_comparator_seq: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It is the sequential successor to the team's fixed 4-bit eq/gt/lt comparator. The block compares two WIDTH-bit operands DIGIT bits per cycle, starting at the MSB digit, and terminates early on the first differing digit. It supports unsigned and two's-complement signed modes and uses a start/busy/done handshake. It sits beside the ALU as a low-area compare unit for sort and threshold logic.

---
 rtl/cmp_pkg.sv | 17 +
 rtl/mag_digit_cmp.sv | 21 ++
 rtl/mag_comparator_seq.sv | 94 +++++++++
 tb/tb_mag_comparator_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package cmp_pkg;

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LT = 2'b10;

  function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mag_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice, yielding a 2-bit result code.
module mag_digit_cmp
  import cmp_pkg::*;
#(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic [1:0]       res
);

  always_comb begin
    res = RES_EQ;
    if (a > b) begin
      res = RES_GT;
    end else if (a < b) begin
      res = RES_LT;
    end
  end

endmodule

// File: rtl/mag_comparator_seq.sv
// Multi-cycle magnitude comparator: walks DIGIT bits per cycle from the MSB,
// stopping at the first differing digit; signed mode via offset-binary mapping.
module mag_comparator_seq
  import cmp_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DIGIT = 4,
  localparam int unsigned NDIG  = ndig(WIDTH, DIGIT),
  localparam int unsigned CW    = $clog2(NDIG + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    digits_used
);

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST_CNT = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] flip;
  logic [1:0]       res;
  logic             finish;

  // Flipping the sign bit maps two's complement onto an order-preserving unsigned range.
  assign flip = signed_mode ? MSB_MASK : '0;

  mag_digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a   (sh_a[WIDTH-1 -: DIGIT]),
    .b   (sh_b[WIDTH-1 -: DIGIT]),
    .res (res)
  );

  assign finish = (res != RES_EQ) || (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      eq          <= 1'b0;
      gt          <= 1'b0;
      lt          <= 1'b0;
      digits_used <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a ^ flip;
            sh_b  <= b ^ flip;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (finish) begin
            // Equal-to-the-end also lands here, with cnt+1 == NDIG.
            eq          <= (res == RES_EQ);
            gt          <= (res == RES_GT);
            lt          <= (res == RES_LT);
            digits_used <= cnt + 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Self-checking bench: directed scenarios on WIDTH=16/DIGIT=4, random sweep on DIGIT=1 and DIGIT=16.
module tb_mag_comparator_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_m, start_1, start_16;
  logic        sm;
  logic [15:0] a, b;

  logic        busy_m, done_m, eq_m, gt_m, lt_m;
  logic [2:0]  du_m;
  logic        busy_1, done_1, eq_1, gt_1, lt_1;
  logic [4:0]  du_1;
  logic        busy_16, done_16, eq_16, gt_16, lt_16;
  logic [0:0]  du_16;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mag_comparator_seq #(.WIDTH(16), .DIGIT(4)) dut_m (
    .clk(clk), .rst_n(rst_n), .start(start_m), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_m), .done(done_m), .eq(eq_m), .gt(gt_m), .lt(lt_m), .digits_used(du_m)
  );

  mag_comparator_seq #(.WIDTH(16), .DIGIT(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .start(start_1), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_1), .done(done_1), .eq(eq_1), .gt(gt_1), .lt(lt_1), .digits_used(du_1)
  );

  mag_comparator_seq #(.WIDTH(16), .DIGIT(16)) dut_16 (
    .clk(clk), .rst_n(rst_n), .start(start_16), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_16), .done(done_16), .eq(eq_16), .gt(gt_16), .lt(lt_16), .digits_used(du_16)
  );

  // Reference: plain integer compare; digits_used from the first nonzero digit of a^b.
  function automatic void model(input int dg, input logic [15:0] va, input logic [15:0] vb,
                                input logic vsm, output logic [2:0] flags, output int du);
    int sa, sb, x, m;
    sa = vsm ? int'($signed(va)) : int'(va);
    sb = vsm ? int'($signed(vb)) : int'(vb);
    if (sa == sb)     flags = 3'b100;
    else if (sa > sb) flags = 3'b010;
    else              flags = 3'b001;
    x  = int'(va ^ vb);
    m  = (1 << dg) - 1;
    du = 16 / dg;
    for (int i = 0; i < 16 / dg; i++) begin
      if (((x >> (16 - dg * (i + 1))) & m) != 0) begin
        du = i + 1;
        break;
      end
    end
  endfunction

  // Launches one compare on the DIGIT=4 instance; lat = edges after acceptance until done (-1 on timeout).
  task automatic op16(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                      output int lat, output int busy_cyc);
    @(negedge clk);
    a = va; b = vb; sm = vsm; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    lat = -1;
    busy_cyc = busy_m ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_m) begin
        lat = i;
        break;
      end
      if (busy_m) busy_cyc++;
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if ({busy_m, done_m, eq_m, gt_m, lt_m} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags_m: got %b expected 00000", {busy_m, done_m, eq_m, gt_m, lt_m});
    end
    tests_run++;
    if (du_m !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_du_m: got %0d expected 0", du_m);
    end
    tests_run++;
    if ({busy_1, done_1, eq_1, gt_1, lt_1, du_1, busy_16, done_16, eq_16, gt_16, lt_16, du_16} !== 16'b0) begin
      tests_failed++;
      $display("FAIL reset_sweep_duts: got %b expected all zero",
               {busy_1, done_1, eq_1, gt_1, lt_1, du_1, busy_16, done_16, eq_16, gt_16, lt_16, du_16});
    end
  endtask

  task automatic test_unsigned;
    int lat, bc;
    op16(16'h0001, 16'h8000, 1'b0, lat, bc);
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL unsigned_latency: got %0d expected 1", lat); end
    tests_run++;
    if ({eq_m, gt_m, lt_m} !== 3'b001) begin
      tests_failed++; $display("FAIL unsigned_flags: got %b expected 001", {eq_m, gt_m, lt_m});
    end
    tests_run++;
    if (du_m !== 3'd1) begin tests_failed++; $display("FAIL unsigned_du: got %0d expected 1", du_m); end
    tests_run++;
    if (bc !== 1 || busy_m !== 1'b0) begin
      tests_failed++; $display("FAIL unsigned_busy: got %0d cycles (busy_at_done=%b) expected 1 (0)", bc, busy_m);
    end
  endtask

  task automatic test_signed;
    int lat, bc;
    op16(16'h0001, 16'h8000, 1'b1, lat, bc);
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b010_001 || lat !== 1) begin
      tests_failed++;
      $display("FAIL signed_pos_vs_min: got flags=%b du=%0d lat=%0d expected 010/1/1", {eq_m, gt_m, lt_m}, du_m, lat);
    end
    op16(16'hFFFF, 16'h0000, 1'b1, lat, bc);
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b001_001 || lat !== 1) begin
      tests_failed++;
      $display("FAIL signed_neg_vs_zero: got flags=%b du=%0d lat=%0d expected 001/1/1", {eq_m, gt_m, lt_m}, du_m, lat);
    end
  endtask

  task automatic test_equal;
    int lat, bc;
    op16(16'h1234, 16'h1234, 1'b0, lat, bc);
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b100_100 || lat !== 4) begin
      tests_failed++;
      $display("FAIL equal: got flags=%b du=%0d lat=%0d expected 100/4/4", {eq_m, gt_m, lt_m}, du_m, lat);
    end
    op16(16'h1235, 16'h1234, 1'b0, lat, bc);
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b010_100 || lat !== 4) begin
      tests_failed++;
      $display("FAIL last_digit_gt: got flags=%b du=%0d lat=%0d expected 010/4/4", {eq_m, gt_m, lt_m}, du_m, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; sm = 1'b0; start_m = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    a = 16'h0000; b = 16'h0001;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (busy_m !== 1'b1 || done_m !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_busy_edge%0d: got busy=%b done=%b expected 1/0", i, busy_m, done_m);
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if ({done_m, busy_m, eq_m, gt_m, lt_m, du_m} !== 8'b10_100_100) begin
      tests_failed++;
      $display("FAIL b2b_first_result: got done=%b busy=%b flags=%b du=%0d expected 1/0/100/4",
               done_m, busy_m, {eq_m, gt_m, lt_m}, du_m);
    end
    @(negedge clk);
    a = 16'h00F0; b = 16'h00F1;
    @(posedge clk); #1;
    start_m = 1'b0;
    tests_run++;
    if ({busy_m, done_m, eq_m, du_m} !== 6'b10_1_100) begin
      tests_failed++;
      $display("FAIL b2b_accept_hold: got busy=%b done=%b eq=%b du=%0d expected 1/0/1/4", busy_m, done_m, eq_m, du_m);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_m) begin lat = i; break; end
    end
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b001_100 || lat !== 4) begin
      tests_failed++;
      $display("FAIL b2b_second_result: got flags=%b du=%0d lat=%0d expected 001/4/4", {eq_m, gt_m, lt_m}, du_m, lat);
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, bc, seen_done;
    @(negedge clk);
    a = 16'hABCD; b = 16'hABCD; sm = 1'b0; start_m = 1'b1;
    @(posedge clk); #1;
    start_m = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests_run++;
    if (busy_m !== 1'b1) begin tests_failed++; $display("FAIL midop_busy: got %b expected 1", busy_m); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy_m, done_m, eq_m, gt_m, lt_m, du_m} !== 8'b0) begin
      tests_failed++;
      $display("FAIL midop_async_clear: got %b expected 00000000", {busy_m, done_m, eq_m, gt_m, lt_m, du_m});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_m || busy_m) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++; $display("FAIL midop_no_done: got %0d active cycles expected 0", seen_done);
    end
    op16(16'h0001, 16'h0002, 1'b0, lat, bc);
    tests_run++;
    if ({eq_m, gt_m, lt_m, du_m} !== 6'b001_100 || lat !== 4) begin
      tests_failed++;
      $display("FAIL midop_restart: got flags=%b du=%0d lat=%0d expected 001/4/4", {eq_m, gt_m, lt_m}, du_m, lat);
    end
  endtask

  task automatic test_sweep;
    logic [15:0] va, vb;
    logic        vsm;
    logic [2:0]  r1, r16, e1, e16;
    int          u1, u16, d1, d16, lat1, lat16, sel;
    for (int n = 0; n < 1000; n++) begin
      va  = 16'($urandom);
      vsm = 1'($urandom);
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      vb = va;
      else if (sel < 3)  vb = va ^ (16'h0001 << $urandom_range(0, 15));
      else               vb = 16'($urandom);
      @(negedge clk);
      a = va; b = vb; sm = vsm; start_1 = 1'b1; start_16 = 1'b1;
      @(posedge clk); #1;
      start_1 = 1'b0; start_16 = 1'b0;
      lat1 = -1; lat16 = -1; r1 = '0; r16 = '0; u1 = 0; u16 = 0;
      for (int i = 1; i <= 40 && (lat1 < 0 || lat16 < 0); i++) begin
        @(posedge clk); #1;
        if (done_1 && lat1 < 0)   begin lat1 = i;  r1 = {eq_1, gt_1, lt_1};    u1 = int'(du_1);  end
        if (done_16 && lat16 < 0) begin lat16 = i; r16 = {eq_16, gt_16, lt_16}; u16 = int'(du_16); end
      end
      model(1, va, vb, vsm, e1, d1);
      model(16, va, vb, vsm, e16, d16);
      tests_run++;
      if (r1 !== e1 || u1 !== d1 || lat1 !== d1) begin
        tests_failed++;
        $display("FAIL sweep_d1 a=%h b=%h s=%b: got flags=%b du=%0d lat=%0d expected %b/%0d/%0d",
                 va, vb, vsm, r1, u1, lat1, e1, d1, d1);
      end
      tests_run++;
      if (r16 !== e16 || u16 !== d16 || lat16 !== d16) begin
        tests_failed++;
        $display("FAIL sweep_d16 a=%h b=%h s=%b: got flags=%b du=%0d lat=%0d expected %b/%0d/%0d",
                 va, vb, vsm, r16, u16, lat16, e16, d16, d16);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_m = 1'b0; start_1 = 1'b0; start_16 = 1'b0;
    sm = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_unsigned;
    test_signed;
    test_equal;
    test_back_to_back;
    test_reset_mid_op;
    test_sweep;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
